boot_sram_rdback: RTL and testbench
===================================

Name: boot_sram_rdback

Overview:
- Read-back verifier for the boot image copied into SRAM at boot time.
- On start, it reads every word of the boot region at the top of SRAM through an IOb-native read master interface.
- It reads the matching word from the boot ROM read port and compares the two.
- It reports pass/fail, the mismatch count and the first mismatching word index. It sits beside the boot controller and runs after loading finishes, before CPU reset is released.

Parameters:
- DATA_W, 32: data width of SRAM and ROM words.
- ADDR_W, 32: SRAM byte-address width.
- BOOTROM_ADDR_W, 12: boot ROM byte-address width. Word count N = 2**(BOOTROM_ADDR_W-2).
- SRAM_ADDR_W, 15: SRAM byte-address width. Boot region byte base BASE = 2**SRAM_ADDR_W - 2**BOOTROM_ADDR_W.

Ports:
- clk_i  in  1  clock. Single clock domain.
- cke_i  in  1  clock enable. When low, all state holds.
- rst_i  in  1  reset. Synchronous, active-high.
- start_i  in  1  start pulse. Honoured only in IDLE or DONE.
- busy_o  out  1  high in REQ/WAIT/CMP.
- done_o  out  1  level, high in DONE.
- pass_o  out  1  valid when done_o; 1 iff err_cnt_o==0.
- err_cnt_o  out  BOOTROM_ADDR_W-1  saturating mismatch count.
- err_addr_o  out  BOOTROM_ADDR_W-2  word index of the first mismatch.
- sram_avalid_o  out  1  read request valid.
- sram_addr_o  out  ADDR_W  byte address = BASE + 4*w.
- sram_wstrb_o  out  DATA_W/8  constant 0 (reads only).
- sram_ready_i  in  1  request accepted when sram_avalid_o & sram_ready_i.
- sram_rvalid_i  in  1  read data valid, at least 1 cycle after acceptance.
- sram_rdata_i  in  DATA_W  read data.
- rom_en_o  out  1  ROM read enable.
- rom_addr_o  out  BOOTROM_ADDR_W-2  ROM word address = w.
- rom_rdata_i  in  DATA_W  ROM data, valid the cycle after rom_en_o.

Behaviour:
- Reset (rst_i=1 at a clk_i edge; priority over cke_i):
  - state=IDLE, w=0.
  - busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, err_addr_o=0.
  - sram_avalid_o=0, rom_en_o=0.
  - A reset mid-run abandons the outstanding request. Any later sram_rvalid_i is ignored in IDLE.
- IDLE/DONE:
  - start_i=1 clears err_cnt_o, err_addr_o, pass_o and the first-error flag, sets w=0, and moves to REQ.
  - done_o drops on the same edge.
- REQ:
  - sram_avalid_o=1 with sram_addr_o={BASE/4 + w, 2'b00}.
  - rom_en_o = sram_avalid_o & sram_ready_i.
  - Stays in REQ while sram_ready_i=0. Moves to WAIT on acceptance.
  - Only one request is outstanding at a time.
- WAIT:
  - On the first WAIT cycle, rom_q <= rom_rdata_i.
  - On sram_rvalid_i, sram_q <= sram_rdata_i and the state moves to CMP.
  - rvalid can arrive on the first WAIT cycle; both captures then happen together.
- CMP, full-word compare sram_q vs rom_q:
  - On mismatch: err_cnt_o increments, saturating at its maximum value.
  - On the first mismatch, err_addr_o <= w.
  - If w==N-1, go to DONE. Otherwise w <= w+1 and return to REQ.
  - w never wraps.
- DONE:
  - done_o=1, pass_o=(err_cnt_o==0). Results hold until the next start_i or reset.
- start_i while busy_o=1 is ignored.
- Timing:
  - Minimum 3 cycles per word (REQ, WAIT, CMP), so 3*N cycles from start to done_o when ready=1 and rvalid comes 1 cycle after acceptance.
  - Each extra ready-low cycle or extra rvalid cycle adds 1 cycle.
- sram_rvalid_i seen in IDLE, REQ, CMP or DONE is ignored.
- sram_addr_o holds its value while sram_ready_i is low.

Test Plan (BOOTROM_ADDR_W=6 so N=16; SRAM_ADDR_W=8 so BASE=0xC0):
1. SRAM model preloaded equal to ROM, ready=1, rvalid 1 cycle after accept; pulse start_i.
   - Addresses 0xC0..0xFC step 4; rom_addr_o 0..15.
   - done_o rises at cycle 48; pass_o=1, err_cnt_o=0.
2. Word 5 corrupted (0xDEADBEEF) and word 9 corrupted.
   - err_cnt_o=2, err_addr_o=5, pass_o=0.
3. sram_ready_i low for 2 cycles on each request, rvalid delayed 3 cycles.
   - Correct compares; sram_addr_o stable while ready is low.
   - done_o at 16*(3+2+2)=112 cycles.
4. start_i pulsed at word 7 of a run.
   - Ignored; run completes normally.
   - A second start_i after done clears the results and reruns all 16 words.
5. rst_i asserted during WAIT of word 4, then a stale rvalid is delivered.
   - All outputs return to reset values; the stale rvalid is ignored.
   - A new start verifies 16 words from w=0.
6. cke_i low for 10 cycles mid-run.
   - State and outputs frozen.
   - Final result identical to the uninterrupted run, with done_o 10 cycles later.

Source files
------------

// File: rtl/boot_sram_rdback_if.sv
// SRAM read-master and boot-ROM read-port bundle for the boot image read-back verifier.
interface boot_sram_rdback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ROM_AW = 10
) ();
  logic                sram_avalid_o;
  logic [ADDR_W-1:0]   sram_addr_o;
  logic [DATA_W/8-1:0] sram_wstrb_o;
  logic                sram_ready_i;
  logic                sram_rvalid_i;
  logic [DATA_W-1:0]   sram_rdata_i;
  logic                rom_en_o;
  logic [ROM_AW-1:0]   rom_addr_o;
  logic [DATA_W-1:0]   rom_rdata_i;

  modport master (
    output sram_avalid_o, sram_addr_o, sram_wstrb_o, rom_en_o, rom_addr_o,
    input  sram_ready_i, sram_rvalid_i, sram_rdata_i, rom_rdata_i
  );

  modport slave (
    input  sram_avalid_o, sram_addr_o, sram_wstrb_o, rom_en_o, rom_addr_o,
    output sram_ready_i, sram_rvalid_i, sram_rdata_i, rom_rdata_i
  );
endinterface

// File: rtl/boot_sram_rdback.sv
// Reads the boot region at the top of SRAM word by word and compares it
// against the boot ROM, reporting pass/fail, mismatch count and first bad word.
//
// state  | meaning
// IDLE   | after reset, waiting for start_i
// REQ    | SRAM read request presented, waiting for ready
// WAIT   | request accepted, ROM word latched, waiting for rvalid
// CMP    | compare captured SRAM and ROM words, advance or finish
// DONE   | results valid and held until start_i or reset
module boot_sram_rdback #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int BOOTROM_ADDR_W = 12,
  parameter int SRAM_ADDR_W    = 15
) (
  input  logic                      clk_i,
  input  logic                      cke_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [BOOTROM_ADDR_W-2:0] err_cnt_o,
  output logic [BOOTROM_ADDR_W-3:0] err_addr_o,
  boot_sram_rdback_if.master        bus
);

  localparam int                WORD_W = BOOTROM_ADDR_W - 2;
  localparam logic [WORD_W-1:0] LAST_W = '1;
  // Boot region occupies the top 2**BOOTROM_ADDR_W bytes of SRAM.
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'((1 << SRAM_ADDR_W) - (1 << BOOTROM_ADDR_W));

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  state_t                    state;
  logic [WORD_W-1:0]         w;
  logic [DATA_W-1:0]         rom_q;
  logic [DATA_W-1:0]         sram_q;
  logic                      first_wait;
  logic                      err_seen;
  logic [BOOTROM_ADDR_W-2:0] err_cnt;
  logic [WORD_W-1:0]         err_addr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      w          <= '0;
      rom_q      <= '0;
      sram_q     <= '0;
      first_wait <= 1'b0;
      err_seen   <= 1'b0;
      err_cnt    <= '0;
      err_addr   <= '0;
    end else if (cke_i) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            w        <= '0;
            err_seen <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.sram_ready_i) begin
            first_wait <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // ROM data is valid exactly one cycle after the accepting edge.
          first_wait <= 1'b0;
          if (first_wait) rom_q <= bus.rom_rdata_i;
          if (bus.sram_rvalid_i) begin
            sram_q <= bus.sram_rdata_i;
            state  <= S_CMP;
          end
        end
        S_CMP: begin
          if (sram_q != rom_q) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            if (!err_seen) begin
              err_seen <= 1'b1;
              err_addr <= w;
            end
          end
          if (w == LAST_W) begin
            state <= S_DONE;
          end else begin
            w     <= w + 1'b1;
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o     = (state == S_REQ) || (state == S_WAIT) || (state == S_CMP);
  assign done_o     = (state == S_DONE);
  assign pass_o     = (state == S_DONE) && (err_cnt == '0);
  assign err_cnt_o  = err_cnt;
  assign err_addr_o = err_addr;

  assign bus.sram_avalid_o = (state == S_REQ);
  assign bus.sram_addr_o   = BASE + ADDR_W'({w, 2'b00});
  assign bus.sram_wstrb_o  = '0;
  assign bus.rom_en_o      = bus.sram_avalid_o & bus.sram_ready_i;
  assign bus.rom_addr_o    = w;

endmodule

// File: tb/tb_boot_sram_rdback.sv
// Scoreboard bench for boot_sram_rdback with randomized SRAM/ROM images and bus latencies.
module tb_boot_sram_rdback;
  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'hC0;

  logic       clk_i = 1'b0;
  logic       cke_i, rst_i, start_i;
  logic       busy_o, done_o, pass_o;
  logic [4:0] err_cnt_o;
  logic [3:0] err_addr_o;

  boot_sram_rdback_if #(.DATA_W(32), .ADDR_W(32), .ROM_AW(4)) bus ();

  boot_sram_rdback #(
    .DATA_W(32), .ADDR_W(32), .BOOTROM_ADDR_W(6), .SRAM_ADDR_W(8)
  ) dut (
    .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .err_addr_o(err_addr_o), .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int cnt;
    int first;
    bit pass;
    int lat;
  } res_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          rdy_lat = 0;
  int          rv_lat = 1;
  logic [31:0] rom [N];
  logic [31:0] sram_mem [N];
  res_t        exp_res_q [$];
  int          exp_w_q [$];

  // slave-side bookkeeping
  bit pend, av_evt, acc_evt, rv_evt, adv_evt;
  int rv_cnt, rdy_cnt, pw, acc_w;
  bit prev_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Boot ROM: registered read port.
  initial forever begin
    @(posedge clk_i);
    if (bus.rom_en_o === 1'b1) bus.rom_rdata_i <= rom[bus.rom_addr_o];
  end

  // SRAM slave: ready held low rdy_lat cycles per request, rvalid rv_lat cycles after accept.
  initial begin
    pend = 0; av_evt = 0; acc_evt = 0; rv_evt = 0; adv_evt = 0;
    rv_cnt = 0; rdy_cnt = 0; pw = 0; acc_w = 0;
    bus.sram_ready_i = 1'b0; bus.sram_rvalid_i = 1'b0; bus.sram_rdata_i = '0;
    forever begin
      @(negedge clk_i); #1;
      if (adv_evt) begin
        if (rv_evt) pend = 0;
        else if (pend && rv_cnt > 1) rv_cnt--;
        if (av_evt && rdy_cnt > 0) rdy_cnt--;
        if (acc_evt) begin
          pend = 1; rv_cnt = rv_lat; pw = acc_w;
        end
      end
      if (bus.sram_avalid_o !== 1'b1) rdy_cnt = rdy_lat;
      bus.sram_ready_i  = (rdy_cnt == 0);
      bus.sram_rvalid_i = pend && (rv_cnt == 1);
      bus.sram_rdata_i  = bus.sram_rvalid_i ? sram_mem[pw] : $urandom;
      av_evt  = (bus.sram_avalid_o === 1'b1);
      acc_evt = av_evt && bus.sram_ready_i && !rst_i;
      acc_w   = int'((bus.sram_addr_o - BASE) >> 2) & (N - 1);
      rv_evt  = bus.sram_rvalid_i;
      adv_evt = cke_i;
    end
  end

  // Monitor: checks each request against the expected word order and each result on done.
  initial begin
    prev_done = 0;
    forever begin
      @(negedge clk_i); #2;
      if (!rst_i && cke_i && bus.sram_avalid_o === 1'b1) begin
        if (exp_w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr 0x%0h with no expected word", bus.sram_addr_o);
        end else begin
          check("sram_addr", bus.sram_addr_o, BASE + 4 * exp_w_q[0]);
          if (bus.sram_ready_i) begin
            check("rom_en", bus.rom_en_o, 1);
            check("rom_addr", bus.rom_addr_o, exp_w_q[0]);
            check("wstrb", bus.sram_wstrb_o, 0);
            void'(exp_w_q.pop_front());
          end
        end
      end
      if (done_o === 1'b1 && !prev_done) begin
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: no run expected at cycle %0d", cyc);
        end else begin
          res_t r;
          r = exp_res_q.pop_front();
          check("err_cnt", err_cnt_o, r.cnt);
          check("err_addr", err_addr_o, r.first);
          check("pass", pass_o, r.pass);
          check("done_latency", cyc - start_cyc, r.lat);
        end
      end
      prev_done = (done_o === 1'b1);
    end
  end

  task automatic fill(input int ncorrupt);
    for (int i = 0; i < N; i++) begin
      rom[i] = $urandom;
      sram_mem[i] = rom[i];
    end
    for (int j = 0; j < ncorrupt; j++) begin
      int k;
      k = $urandom_range(0, N - 1);
      sram_mem[k] = sram_mem[k] ^ ($urandom | 32'h1);
    end
  endtask

  task automatic start_run(input int rdy, input int rv, input int extra);
    res_t r;
    r.cnt = 0; r.first = 0;
    for (int i = 0; i < N; i++)
      if (sram_mem[i] != rom[i]) begin
        if (r.cnt == 0) r.first = i;
        r.cnt++;
      end
    r.pass = (r.cnt == 0);
    r.lat  = N * (2 + rdy + rv) + extra;
    rdy_lat = rdy;
    rv_lat  = rv;
    for (int i = 0; i < N; i++) exp_w_q.push_back(i);
    exp_res_q.push_back(r);
    @(negedge clk_i);
    start_i = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    if (done_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL done_timeout: done_o not seen within %0d cycles", limit);
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_word(input int wd, input bit in_wait, input int limit);
    int n;
    n = 0;
    while (!(busy_o === 1'b1 && bus.rom_addr_o == wd &&
             (!in_wait || bus.sram_avalid_o === 1'b0)) && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= limit) begin
      checks++; errors++;
      $display("FAIL word_timeout: word %0d not reached within %0d cycles", wd, limit);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_pass"}, pass_o, 0);
    check({tag, "_err_cnt"}, err_cnt_o, 0);
    check({tag, "_err_addr"}, err_addr_o, 0);
    check({tag, "_avalid"}, bus.sram_avalid_o, 0);
    check({tag, "_rom_en"}, bus.rom_en_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cke_i = 1'b1; rst_i = 1'b1; start_i = 1'b0;
    for (int i = 0; i < N; i++) begin rom[i] = '0; sram_mem[i] = '0; end
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // clean image, fastest bus
    fill(0);
    start_run(0, 1, 0);
    wait_done(200);

    // words 5 and 9 corrupted
    fill(0);
    rom[5] = 32'h0BAD_F00D;
    sram_mem[5] = 32'hDEADBEEF;
    sram_mem[9] = ~rom[9];
    start_run(0, 1, 0);
    wait_done(200);

    // slow ready and late rvalid
    fill(1);
    start_run(2, 3, 0);
    wait_done(400);

    // start while busy is ignored; a later start clears results
    fill(2);
    start_run(0, 1, 0);
    wait_word(7, 0, 200);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(200);
    fill(0);
    start_run(1, 2, 0);
    wait_done(300);

    // reset during WAIT of word 4, stale rvalid delivered afterwards
    fill(0);
    start_run(0, 3, 0);
    wait_word(4, 1, 200);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_w_q.delete();
    exp_res_q.delete();
    check_reset_outputs("midrun_reset");
    repeat (6) @(negedge clk_i);
    check("stale_rv_busy", busy_o, 0);
    check("stale_rv_done", done_o, 0);
    check("stale_rv_err_cnt", err_cnt_o, 0);
    fill(1);
    start_run(0, 1, 0);
    wait_done(200);

    // clock enable low for 10 cycles mid-run
    fill(1);
    start_run(1, 1, 10);
    repeat (20) @(negedge clk_i);
    cke_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("freeze_busy", busy_o, 1);
    end
    cke_i = 1'b1;
    wait_done(300);

    // randomized images and latencies
    for (int t = 0; t < 4; t++) begin
      fill($urandom_range(0, 3));
      start_run($urandom_range(0, 3), $urandom_range(1, 4), 0);
      wait_done(500);
    end

    check("leftover_results", exp_res_q.size(), 0);
    check("leftover_requests", exp_w_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
